serial_subtractor: RTL and testbench

- Bit-serial WIDTH-bit subtractor. Computes diff = a - b - bin one bit per clock, LSB first.
- Uses one full_subtractor cell plus a registered borrow, so it consumes the combinational full_subtractor stage directly.
- Serves area-constrained datapaths that trade latency for a single 1-bit arithmetic cell.
- Start/busy/done handshake toward the controlling FSM.

---
 rtl/serial_subtractor_pkg.sv | 12 +
 rtl/serial_subtractor_if.sv | 27 ++
 rtl/serial_subtractor_full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 91 +++++++++
 tb/tb_serial_subtractor.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default width.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bus between a controller and the serial subtractor.
interface serial_subtractor_if
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
  );

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: diff = a - b - c, bor = borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic diff,
  output logic bor
);

  assign diff = a ^ b ^ c;
  assign bor  = (~a & b) | (~(a ^ b) & c);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one full_subtractor cell plus a registered borrow.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_subtractor_if.slave bus
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] diff_sr;
  logic [WIDTH-1:0] diff_q;
  logic             brw;
  logic             bout_q;
  logic [CW-1:0]    cnt;
  logic             cell_diff;
  logic             cell_bor;

  full_subtractor u_fs (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .c    (brw),
    .diff (cell_diff),
    .bor  (cell_bor)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = RUN;
      RUN:     if (cnt == LAST) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      diff_sr <= '0;
      diff_q  <= '0;
      brw     <= 1'b0;
      bout_q  <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sr <= bus.a;
            b_sr <= bus.b;
            brw  <= bus.bin;
            cnt  <= '0;
          end
        end
        RUN: begin
          diff_sr <= {cell_diff, diff_sr[WIDTH-1:1]};
          a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
          brw     <= cell_bor;
          cnt     <= cnt + 1'b1;
          // Result registers take the final bit directly so they are valid on entry to DONE.
          if (cnt == LAST) begin
            diff_q <= {cell_diff, diff_sr[WIDTH-1:1]};
            bout_q <= cell_bor;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8) plus a WIDTH=4 exhaustive sweep.
module tb_serial_subtractor;

  logic clk;
  logic rst_n;

  serial_subtractor_if #(.WIDTH(8)) bus8 ();
  serial_subtractor_if #(.WIDTH(4)) bus4 ();

  serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  int n_cmp;
  int n_err;
  int k;
  int bc;
  int ndone;
  int prev_t;
  int idle_cnt;
  logic [4:0] mdl;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                      input logic [7:0] ed, input logic eb, input string tag);
    int lat;
    int busy_cyc;
    logic got;
    @(negedge clk);
    bus8.a = a; bus8.b = b; bus8.bin = bin; bus8.start = 1'b1;
    @(posedge clk);
    #1 bus8.start = 1'b0;
    lat = 0; busy_cyc = 0; got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus8.busy) busy_cyc++;
      if (bus8.done) got = 1'b1;
    end
    check({tag, " latency"}, lat, 9);
    check({tag, " busy cycles"}, busy_cyc, 9);
    check({tag, " diff"}, bus8.diff, ed);
    check({tag, " bout"}, bus8.bout, eb);
    @(negedge clk);
    check({tag, " idle busy"}, bus8.busy, 0);
    check({tag, " idle done"}, bus8.done, 0);
    check({tag, " diff hold"}, bus8.diff, ed);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.bin = 1'b0;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.bin = 1'b0;
    #12;
    check("rst busy", bus8.busy, 0);
    check("rst done", bus8.done, 0);
    check("rst diff", bus8.diff, 0);
    check("rst bout", bus8.bout, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run8(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, "5A-3C");
    run8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, "00-01");
    run8(8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, "10-10-1");
    run8(8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0, "FF-00-1");

    // Start requests during RUN and DONE must be ignored
    @(negedge clk);
    bus8.a = 8'h80; bus8.b = 8'h01; bus8.bin = 1'b0; bus8.start = 1'b1;
    @(posedge clk);
    #1 bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    bus8.a = 8'h00; bus8.b = 8'hFF; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    k = 0;
    while (!bus8.done && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("ign done seen", bus8.done, 1);
    check("ign diff", bus8.diff, 8'h7F);
    check("ign bout", bus8.bout, 0);
    bus8.start = 1'b1;
    @(posedge clk);
    #1 bus8.start = 1'b0;
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus8.done) ndone++;
    end
    check("ign extra done", ndone, 0);
    check("ign busy after", bus8.busy, 0);
    check("ign diff after", bus8.diff, 8'h7F);

    // Back-to-back with start held high
    @(negedge clk);
    bus8.a = 8'h33; bus8.b = 8'h11; bus8.bin = 1'b0; bus8.start = 1'b1;
    ndone = 0; prev_t = 0; idle_cnt = 0;
    for (int t = 1; t <= 40; t++) begin
      @(negedge clk);
      if (!bus8.busy) idle_cnt++;
      if (bus8.done) begin
        ndone++;
        check("b2b diff", bus8.diff, 8'h22);
        check("b2b bout", bus8.bout, 0);
        if (prev_t == 0) check("b2b first", t, 9);
        else begin
          check("b2b period", t - prev_t, 10);
          check("b2b idle gap", idle_cnt, 1);
        end
        prev_t = t;
        idle_cnt = 0;
      end
    end
    bus8.start = 1'b0;
    check("b2b count", ndone, 4);
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of an operation
    bus8.a = 8'hAA; bus8.b = 8'h55; bus8.bin = 1'b0; bus8.start = 1'b1;
    @(posedge clk);
    #1 bus8.start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mid rst busy", bus8.busy, 0);
    check("mid rst done", bus8.done, 0);
    check("mid rst diff", bus8.diff, 0);
    check("mid rst bout", bus8.bout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus8.done) ndone++;
    end
    check("mid rst no done", ndone, 0);
    run8(8'h0F, 8'h01, 1'b0, 8'h0E, 1'b0, "0F-01");

    // Exhaustive WIDTH=4 sweep against an arithmetic reference
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      bus4.a = 4'(i); bus4.b = 4'(i >> 4); bus4.bin = i[8]; bus4.start = 1'b1;
      @(posedge clk);
      #1 bus4.start = 1'b0;
      k = 0;
      while (!bus4.done && k < 12) begin
        @(negedge clk);
        k++;
      end
      mdl = {1'b0, bus4.a} - {1'b0, bus4.b} - {4'b0, bus4.bin};
      check($sformatf("w4 diff i=%0d", i), bus4.diff, mdl[3:0]);
      check($sformatf("w4 bout i=%0d", i), bus4.bout, mdl[4]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
